// File: rtl/mbist_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mbist_ctrl_pkg
// Purpose  : Shared types and constants for the March MBIST controller.
//            state_t   - controller state encoding (ST_RESET is the reset value)
//            c_MARCH_CM_DIR_MASK - direction mask of March C- (elements 3 and 4
//                        run address-descending)
// Revision : 1.0 - initial release
// ============================================================================
package mbist_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_TEST  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [5:0] c_MARCH_CM_DIR_MASK = 6'b011000;

endpackage
`default_nettype wire

// File: rtl/mbist_ret_timer.sv
`default_nettype none
// ============================================================================
// Module   : mbist_ret_timer
// Purpose  : Loadable down-counter timing the retention pause between March
//            elements. Saturates at zero.
// Ports    : clk        - clock
//            rst        - asynchronous active-low reset (count -> 0)
//            i_load     - load i_load_val into the counter
//            i_load_val - value to load (pause length minus one)
//            i_dec      - decrement when non-zero
//            o_zero     - counter is zero
// Revision : 1.0 - initial release
// ============================================================================
module mbist_ret_timer #(
    parameter  int unsigned RET_CYCLES = 16,
    localparam int unsigned TW         = $clog2(RET_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mbist_march_controller.sv
`default_nettype none
// ============================================================================
// Module   : mbist_march_controller
// Purpose  : Sequences a NUM_ELEM-element March algorithm. Drives the address
//            counter load/direction and the test/normal mux, inserts optional
//            retention pauses between elements and folds comparator
//            mismatches into a pass/fail result.
// Ports    : clk      - clock, all state on rising edge
//            rst      - asynchronous active-low reset
//            start    - begin test (honoured in RESET or DONE only)
//            cout     - address counter terminal count
//            fail     - comparator mismatch (valid while NbarT=1, ld=0)
//            ld       - load address counter to start address
//            NbarT    - 1 = test path selected
//            up       - address direction of current element
//            elem     - current March element index
//            busy     - test in progress (TEST/LOAD/PAUSE)
//            done     - test finished
//            pass_ok  - no fail seen (valid with done)
//            err_elem - element of first fail, 0 if none
// Revision : 1.0 - initial release
// ============================================================================
module mbist_march_controller
    import mbist_ctrl_pkg::*;
#(
    parameter  int unsigned         NUM_ELEM     = 6,
    parameter  logic [NUM_ELEM-1:0] DIR_MASK     = c_MARCH_CM_DIR_MASK,
    parameter  logic [NUM_ELEM-1:0] PAUSE_MASK   = '0,
    parameter  int unsigned         RET_CYCLES   = 16,
    parameter  bit                  STOP_ON_FAIL = 1'b1,
    localparam int unsigned         EW           = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cout,
    input  logic          fail,
    output logic          ld,
    output logic          NbarT,
    output logic          up,
    output logic [EW-1:0] elem,
    output logic          busy,
    output logic          done,
    output logic          pass_ok,
    output logic [EW-1:0] err_elem
);

    // Element 0 is never preceded by a pause, and RET_CYCLES=0 disables all.
    localparam logic [NUM_ELEM-1:0] c_PAUSE_EFF =
        (RET_CYCLES > 0) ? (PAUSE_MASK & ~NUM_ELEM'(1)) : '0;

    state_t        r_state, w_state_nxt;
    logic [EW-1:0] r_elem, w_elem_nxt;
    logic [EW-1:0] r_err_elem, w_err_nxt;
    logic          r_sticky, w_sticky_nxt;

    logic [EW-1:0] w_elem_inc;
    logic          w_last;
    logic          w_pause_sel;
    logic          w_dir_sel;
    logic          w_timer_load;
    logic          w_timer_dec;
    logic          w_ret_zero;

    assign w_elem_inc  = r_elem + EW'(1);
    assign w_last      = (r_elem == EW'(NUM_ELEM - 1));
    assign w_timer_dec = (r_state == ST_PAUSE);

    // Mask lookups by loop so out-of-range index values never select a bit.
    always_comb begin
        w_pause_sel = 1'b0;
        w_dir_sel   = 1'b0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            if (w_elem_inc == EW'(i)) w_pause_sel = c_PAUSE_EFF[i];
            if (r_elem == EW'(i))     w_dir_sel   = DIR_MASK[i];
        end
    end

    generate
        if (RET_CYCLES > 0) begin : g_ret_timer
            localparam int unsigned TW = $clog2(RET_CYCLES + 1);
            mbist_ret_timer #(
                .RET_CYCLES (RET_CYCLES)
            ) u_ret_timer (
                .clk        (clk),
                .rst        (rst),
                .i_load     (w_timer_load),
                .i_load_val (TW'(RET_CYCLES - 1)),
                .i_dec      (w_timer_dec),
                .o_zero     (w_ret_zero)
            );
        end else begin : g_no_ret_timer
            logic w_unused_timer;
            assign w_unused_timer = w_timer_load ^ w_timer_dec;
            assign w_ret_zero     = 1'b1;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RESET;
            r_elem     <= '0;
            r_err_elem <= '0;
            r_sticky   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_elem     <= w_elem_nxt;
            r_err_elem <= w_err_nxt;
            r_sticky   <= w_sticky_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_elem_nxt   = r_elem;
        w_err_nxt    = r_err_elem;
        w_sticky_nxt = r_sticky;
        w_timer_load = 1'b0;
        case (r_state)
            ST_RESET: begin
                // Counter was already held in load during RESET.
                if (start) begin
                    w_state_nxt = ST_TEST;
                    w_elem_nxt  = '0;
                end
            end
            ST_TEST: begin
                if (fail) begin
                    w_sticky_nxt = 1'b1;
                    if (!r_sticky) w_err_nxt = r_elem;
                end
                // Abort-on-fail has priority over a coincident terminal count.
                if (fail && STOP_ON_FAIL) begin
                    w_state_nxt = ST_DONE;
                end else if (cout) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_elem_nxt = w_elem_inc;
                        if (w_pause_sel) begin
                            w_state_nxt  = ST_PAUSE;
                            w_timer_load = 1'b1;
                        end else begin
                            w_state_nxt  = ST_LOAD;
                        end
                    end
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_TEST;
            end
            ST_PAUSE: begin
                if (w_ret_zero) w_state_nxt = ST_TEST;
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt  = ST_TEST;
                    w_elem_nxt   = '0;
                    w_err_nxt    = '0;
                    w_sticky_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    // Moore output decode
    always_comb begin
        ld      = 1'b1;
        NbarT   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        pass_ok = 1'b0;
        case (r_state)
            ST_TEST: begin
                ld    = 1'b0;
                NbarT = 1'b1;
                busy  = 1'b1;
            end
            ST_LOAD, ST_PAUSE: begin
                NbarT = 1'b1;
                busy  = 1'b1;
            end
            ST_DONE: begin
                done    = 1'b1;
                pass_ok = ~r_sticky;
            end
            default: begin
                ld = 1'b1;
            end
        endcase
    end

    assign up       = ~w_dir_sel;
    assign elem     = r_elem;
    assign err_elem = r_err_elem;

endmodule
`default_nettype wire

// File: tb/tb_mbist_march_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbist_march_controller
// Purpose  : Self-checking bench. Instance 0 uses default parameters
//            (March C-, no pauses, stop on fail). Instance 1 uses a 4-cycle
//            pause before element 3 and runs to completion on fail. Both are
//            compared every cycle against an abstract reference model that
//            tracks "running", "finished" and a remaining-gap count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbist_march_controller;

    localparam logic [5:0] DIRM = 6'b011000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] start_v = '0;
    logic [1:0] cout_v  = '0;
    logic [1:0] fail_v  = '0;

    logic       ld0, nbart0, up0, busy0, done0, pass0;
    logic [2:0] elem0, err0;
    logic       ld1, nbart1, up1, busy1, done1, pass1;
    logic [2:0] elem1, err1;

    mbist_march_controller u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .cout(cout_v[0]), .fail(fail_v[0]),
        .ld(ld0), .NbarT(nbart0), .up(up0), .elem(elem0), .busy(busy0),
        .done(done0), .pass_ok(pass0), .err_elem(err0)
    );

    mbist_march_controller #(
        .PAUSE_MASK(6'b001000), .RET_CYCLES(4), .STOP_ON_FAIL(1'b0)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .cout(cout_v[1]), .fail(fail_v[1]),
        .ld(ld1), .NbarT(nbart1), .up(up1), .elem(elem1), .busy(busy1),
        .done(done1), .pass_ok(pass1), .err_elem(err1)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_active   [2];
    bit m_finished [2];
    bit m_sf       [2];
    int m_gap      [2];
    int m_elem     [2];
    int m_err      [2];

    function automatic logic [5:0] cfg_pmask(int i);
        return (i == 1) ? 6'b001000 : 6'b000000;
    endfunction
    function automatic int cfg_ret(int i);
        return (i == 1) ? 4 : 16;
    endfunction
    function automatic bit cfg_stop(int i);
        return (i == 1) ? 1'b0 : 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_finished[i] = 0; m_sf[i] = 0;
            m_gap[i] = 0; m_elem[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit s, input bit c, input bit f);
        logic [5:0] pm;
        pm = cfg_pmask(i);
        if (!m_active[i]) begin
            if (s) begin
                m_active[i] = 1; m_finished[i] = 0; m_sf[i] = 0;
                m_elem[i] = 0; m_err[i] = 0; m_gap[i] = 0;
            end
        end else if (m_gap[i] > 0) begin
            m_gap[i]--;
        end else begin
            if (f && !m_sf[i]) begin
                m_sf[i] = 1; m_err[i] = m_elem[i];
            end
            if (f && cfg_stop(i)) begin
                m_active[i] = 0; m_finished[i] = 1;
            end else if (c) begin
                if (m_elem[i] == 5) begin
                    m_active[i] = 0; m_finished[i] = 1;
                end else begin
                    m_elem[i]++;
                    m_gap[i] = (cfg_ret(i) > 0 && pm[m_elem[i]]) ? cfg_ret(i) : 1;
                end
            end
        end
    endtask

    // {ld, NbarT, up, busy, done, pass_ok, elem, err_elem}
    function automatic logic [11:0] exp_outs(int i);
        logic [5:0] d;
        d = DIRM;
        return {(!m_active[i] || m_gap[i] > 0), m_active[i], !d[m_elem[i]],
                m_active[i], m_finished[i], (m_finished[i] && !m_sf[i]),
                3'(m_elem[i]), 3'(m_err[i])};
    endfunction

    function automatic logic [11:0] obs_outs(int i);
        if (i == 0) return {ld0, nbart0, up0, busy0, done0, pass0, elem0, err0};
        return {ld1, nbart1, up1, busy1, done1, pass1, elem1, err1};
    endfunction

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++)
            check($sformatf("outs%0d", i), 32'(obs_outs(i)), 32'(exp_outs(i)));
    endtask

    // Check outputs mid-cycle, apply inputs, then advance model on the edge.
    task automatic drive(input bit s0, input bit c0, input bit f0,
                         input bit s1, input bit c1, input bit f1);
        @(negedge clk);
        check_all();
        start_v = {s1, s0};
        cout_v  = {c1, c0};
        fail_v  = {f1, f0};
        @(posedge clk);
        if (rst) begin
            model_step(0, s0, c0, f0);
            model_step(1, s1, c1, f1);
        end
    endtask

    initial begin
        bit s0, c0, f0, s1, c1, f1;

        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;

        // Full March C- run on both; instance 1 fails in e1 and e4.
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 7; k++)
                drive(0, 0, 0, 0, 0, bit'((e == 1 || e == 4) && k == 3));
            drive(0, 1, 0, 0, 1, 0);
        end
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t1_done",  32'(done0), 32'd1);
        check("t1_pass",  32'(pass0), 32'd1);
        check("t1_err",   32'(err0),  32'd0);
        check("t1_elem",  32'(elem0), 32'd5);
        check("t4_done",  32'(done1), 32'd1);
        check("t4_pass",  32'(pass1), 32'd0);
        check("t4_err",   32'(err1),  32'd1);

        // Restart from DONE; instance 0 fails with cout in e2,
        // instance 1 keeps start asserted throughout.
        drive(1, 0, 0, 1, 0, 0);
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 7; k++) drive(0, 0, 0, 1, 0, 0);
            drive(0, bit'(e <= 2), bit'(e == 2), 1, 1, 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t3_done", 32'(done0), 32'd1);
        check("t3_pass", 32'(pass0), 32'd0);
        check("t3_err",  32'(err0),  32'd2);
        check("t3_elem", 32'(elem0), 32'd2);

        // Asynchronous reset in the middle of element 3.
        drive(1, 0, 0, 1, 0, 0);
        for (int e = 0; e < 3; e++) begin
            for (int k = 0; k < 7; k++) drive(0, 0, 0, 0, 0, 0);
            drive(0, 1, 0, 0, 1, 0);
        end
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("t5_ld",    32'(ld0),    32'd1);
        check("t5_nbart", 32'(nbart0), 32'd0);
        check("t5_elem",  32'(elem0),  32'd0);
        check("t5_busy",  32'(busy0),  32'd0);
        check_all();
        repeat (2) drive(1, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("t5_start_in_rst", 32'(busy0), 32'd0);
        start_v = '0; cout_v = '0; fail_v = '0;
        rst = 1'b1;

        // cout while in RESET must not leave RESET.
        repeat (3) drive(0, 1, 0, 0, 1, 0);
        @(negedge clk);
        check("t6_cout_reset", 32'(busy0), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            s0 = ($urandom_range(0, 7) == 0);
            c0 = ($urandom_range(0, 4) == 0);
            f0 = ($urandom_range(0, 39) == 0);
            s1 = ($urandom_range(0, 7) == 0);
            c1 = ($urandom_range(0, 4) == 0);
            f1 = ($urandom_range(0, 29) == 0);
            drive(s0, c0, f0, s1, c1, f1);
        end
        @(negedge clk);
        check_all();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
